// File: rtl/vend_dispenser.sv
// Plays a vend result out as timed LED pulses: one gruel pulse, then one coin
// pulse per unit of change, with a gap after each item and a lifetime vend counter.
module vend_dispenser #(
  parameter int PULSE_CYCLES = 25000000,
  parameter int GAP_CYCLES   = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vend_req,
  input  logic       gruel,
  input  logic [2:0] change,
  output logic       gruel_led,
  output logic       coin_led,
  output logic       busy,
  output logic [2:0] coins_left,
  output logic       done,
  output logic [7:0] vend_count
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRUEL_ON,
    GRUEL_GAP,
    COIN_ON,
    COIN_GAP,
    DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_vend_req_d;
  logic            r_gruel;
  logic            r_gruel_led;
  logic            r_coin_led;
  logic            r_busy;
  logic [2:0]      r_coins_left;
  logic            r_done;
  logic [7:0]      r_vend_count;
  logic            w_accept;
  logic            w_cnt_zero;

  assign w_accept   = (r_state == IDLE) && vend_req && !r_vend_req_d;
  assign w_cnt_zero = (r_cnt == '0);

  // Outputs are driven on the edge that enters each state, so they track the state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_vend_req_d <= 1'b1;
      r_gruel      <= 1'b0;
      r_gruel_led  <= 1'b0;
      r_coin_led   <= 1'b0;
      r_busy       <= 1'b0;
      r_coins_left <= '0;
      r_done       <= 1'b0;
      r_vend_count <= '0;
    end else begin
      r_vend_req_d <= vend_req;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_gruel      <= gruel;
            r_coins_left <= change;
            r_busy       <= 1'b1;
            r_cnt        <= PULSE_LOAD;
            if (gruel) begin
              r_state     <= GRUEL_ON;
              r_gruel_led <= 1'b1;
            end else if (change != '0) begin
              r_state    <= COIN_ON;
              r_coin_led <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        GRUEL_ON: begin
          if (w_cnt_zero) begin
            r_state     <= GRUEL_GAP;
            r_gruel_led <= 1'b0;
            r_cnt       <= GAP_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        COIN_ON: begin
          if (w_cnt_zero) begin
            r_state      <= COIN_GAP;
            r_coin_led   <= 1'b0;
            r_coins_left <= r_coins_left - 1'b1;
            r_cnt        <= GAP_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GRUEL_GAP, COIN_GAP: begin
          if (w_cnt_zero) begin
            if (r_coins_left != '0) begin
              r_state    <= COIN_ON;
              r_coin_led <= 1'b1;
              r_cnt      <= PULSE_LOAD;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          if (r_gruel) r_vend_count <= r_vend_count + 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_gruel_led <= 1'b0;
          r_coin_led  <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign gruel_led  = r_gruel_led;
  assign coin_led   = r_coin_led;
  assign busy       = r_busy;
  assign coins_left = r_coins_left;
  assign done       = r_done;
  assign vend_count = r_vend_count;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser with PULSE_CYCLES=4, GAP_CYCLES=2;
// cycle k below means k cycles after the accept edge (sampled on negedge).
module tb_vend_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       vend_req;
  logic       gruel;
  logic [2:0] change;
  logic       gruel_led;
  logic       coin_led;
  logic       busy;
  logic [2:0] coins_left;
  logic       done;
  logic [7:0] vend_count;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [7:0]  exp_cnt = '0;

  vend_dispenser #(.PULSE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .vend_req   (vend_req),
    .gruel      (gruel),
    .change     (change),
    .gruel_led  (gruel_led),
    .coin_led   (coin_led),
    .busy       (busy),
    .coins_left (coins_left),
    .done       (done),
    .vend_count (vend_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_gled"},  32'(gruel_led), 0);
    check({tag, "_cled"},  32'(coin_led), 0);
    check({tag, "_coins"}, 32'(coins_left), 0);
  endtask

  // Returns just after the accept edge (start of cycle T).
  task automatic start_vend(input logic g, input logic [2:0] c);
    @(negedge clk);
    vend_req = 1'b0;
    @(negedge clk);
    vend_req = 1'b1;
    gruel    = g;
    change   = c;
    @(posedge clk);
  endtask

  task automatic run_full(input bit glitch, input string tag);
    start_vend(1'b1, 3'd2);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (glitch) begin
        if (k == 2) begin gruel = 1'b0; change = 3'd7; end
        if (k == 4) vend_req = 1'b0;
        if (k == 5) vend_req = 1'b1;
      end
      check($sformatf("%s_gled_%0d", tag, k), 32'(gruel_led), 32'(k >= 1 && k <= 4));
      check($sformatf("%s_cled_%0d", tag, k), 32'(coin_led),
            32'((k >= 7 && k <= 10) || (k >= 13 && k <= 16)));
      check($sformatf("%s_coins_%0d", tag, k), 32'(coins_left),
            (k <= 10) ? 2 : (k <= 16) ? 1 : 0);
      check($sformatf("%s_busy_%0d", tag, k), 32'(busy), 32'(k <= 19));
      check($sformatf("%s_done_%0d", tag, k), 32'(done), 32'(k == 19));
      if (k == 20) exp_cnt = exp_cnt + 1'b1;
      check($sformatf("%s_cnt_%0d", tag, k), 32'(vend_count), 32'(exp_cnt));
    end
    // vend_req still high: no new vend may start
    repeat (4) begin
      @(negedge clk);
      check_idle({tag, "_held"});
    end
  endtask

  initial begin
    reset    = 1'b1;
    vend_req = 1'b1;
    gruel    = 1'b0;
    change   = 3'd0;
    #12;
    check_idle("rst");
    check("rst_cnt", 32'(vend_count), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_idle("rst_held_req");
    end

    run_full(1'b0, "full");
    run_full(1'b1, "glitch");

    start_vend(1'b0, 3'd0);
    @(negedge clk);
    check("zero_done_1", 32'(done), 1);
    check("zero_busy_1", 32'(busy), 1);
    check("zero_gled_1", 32'(gruel_led), 0);
    check("zero_cled_1", 32'(coin_led), 0);
    @(negedge clk);
    check_idle("zero_2");
    check("zero_cnt", 32'(vend_count), 32'(exp_cnt));

    start_vend(1'b0, 3'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("chg_cled_%0d", k), 32'(coin_led), 32'(k <= 4));
      check($sformatf("chg_gled_%0d", k), 32'(gruel_led), 0);
      check($sformatf("chg_coins_%0d", k), 32'(coins_left), 32'(k <= 4));
      check($sformatf("chg_done_%0d", k), 32'(done), 32'(k == 7));
      check($sformatf("chg_busy_%0d", k), 32'(busy), 32'(k <= 7));
    end
    check("chg_cnt", 32'(vend_count), 32'(exp_cnt));

    start_vend(1'b1, 3'd2);
    repeat (8) @(negedge clk);
    check("ar_cled_pre", 32'(coin_led), 1);
    #1 reset = 1'b1;
    #1;
    check_idle("ar");
    check("ar_cnt", 32'(vend_count), 0);
    exp_cnt = '0;
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_idle("ar_after");
    end

    for (int i = 0; i < 256; i++) begin
      bit seen;
      seen = 1'b0;
      start_vend(1'b1, 3'd0);
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      if (!seen) check($sformatf("wrap_timeout_%0d", i), 0, 1);
      @(negedge clk);
      if (i == 254) check("wrap_255", 32'(vend_count), 255);
      if (i == 255) check("wrap_0", 32'(vend_count), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream of the vending state logic: consumes the gruel flag and 3-bit change count.
- Plays them out as timed, human-visible pulses: one gruel pulse, then one coin pulse per unit of change.
- Sits on the 50 MHz board clock next to the LED/seven-segment outputs; drives gruel/coin LEDs, a remaining-coin count for the change display, and a lifetime vend counter.

Parameters:
- PULSE_CYCLES, 25000000, LED on-time per dispensed item in clk cycles (>=1; 0.5 s at 50 MHz).
- GAP_CYCLES, 12500000, LED off-time after each item in clk cycles (>=1).

Ports:
- clk  input  1  50 MHz board clock.
- reset  input  1  asynchronous, active-high reset.
- vend_req  input  1  debounced vend button level; a vend starts on its rising edge.
- gruel  input  1  gruel owed; sampled only on the accept cycle.
- change  input  3  coins of change owed (0-7); sampled only on the accept cycle.
- gruel_led  output  1  high while gruel is being dispensed.
- coin_led  output  1  high while one coin is being dispensed.
- busy  output  1  high from the cycle after accept through the done cycle.
- coins_left  output  3  coins still to dispense.
- done  output  1  one-cycle pulse when the vend sequence completes.
- vend_count  output  8  completed vends that included gruel; wraps.

Behaviour:
- All outputs and state registers are registered and cleared asynchronously by reset.
- Reset values: gruel_led=0, coin_led=0, busy=0, coins_left=0, done=0, vend_count=0, state=IDLE.
- Edge detector register vend_req_d resets to 1, so a vend_req held high through reset does not trigger a vend.
- Accept: in IDLE, when vend_req=1 and vend_req_d=0. Call this cycle T.
  - On accept, latch gruel, and load coins_left=change.
  - Rising edges while not in IDLE are discarded, not queued.
- States: IDLE, GRUEL_ON, GRUEL_GAP, COIN_ON, COIN_GAP, DONE.
- One down-counter, width $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1), times every ON and GAP phase.
- Transitions from IDLE at accept:
  - gruel=1 -> GRUEL_ON.
  - gruel=0 and change>0 -> COIN_ON.
  - gruel=0 and change=0 -> DONE.
- GRUEL_ON: gruel_led=1 for exactly PULSE_CYCLES cycles, then GRUEL_GAP.
- GRUEL_GAP: GAP_CYCLES cycles, then COIN_ON if coins_left>0, else DONE.
- COIN_ON: coin_led=1 for exactly PULSE_CYCLES cycles, then COIN_GAP.
  - coins_left decrements by 1 on the first COIN_GAP cycle, i.e. the cycle coin_led falls.
- COIN_GAP: GAP_CYCLES cycles, then COIN_ON if coins_left>0, else DONE.
- DONE (single cycle): done=1, busy=1.
  - vend_count increments modulo 256 if the latched gruel=1.
  - Next state IDLE.
- LED outputs change the cycle after the state-entering edge, i.e. gruel_led or coin_led first goes high at T+1.
- gruel_led and coin_led are never high in the same cycle. No LED is high in DONE or IDLE.
- In IDLE: busy=0, done=0, coins_left holds 0.
- Reset asserted mid-sequence: all outputs drop to reset values immediately, without waiting for a clock. The sequence is abandoned, not resumed.
- Inputs gruel and change may change freely while busy; they have no effect until the next accept.

Test Plan:
All cases use PULSE_CYCLES=4, GAP_CYCLES=2.
- Full vend: gruel=1, change=2, accept at T.
  - gruel_led high T+1..T+4, low T+5..T+6.
  - coin_led high T+7..T+10 and T+13..T+16.
  - coins_left = 2 -> 1 at T+11 -> 0 at T+17.
  - done at T+19; busy high T+1..T+19; vend_count 0 -> 1.
- Zero vend: gruel=0, change=0, accept at T -> done=1 and busy=1 at T+1 only, no LED activity, vend_count unchanged.
- Change-only: gruel=0, change=1, accept at T -> coin_led T+1..T+4, coins_left 0 at T+5, done at T+7, vend_count unchanged.
- Ignored requests:
  - Second rising edge of vend_req at T+5 of a full vend -> sequence and timing identical to case 1.
  - vend_req held high after done -> no new vend until it falls and rises again.
- Async reset at T+8 of case 1 (coin_led high):
  - All outputs 0 before the next clk edge; vend_count=0.
  - After release with vend_req high, no vend starts.
- Wrap: 256 consecutive gruel vends -> vend_count reads 255 after the 255th done and 0 after the 256th.
